// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract sequencer.
// A WORDS x 16-bit operation is processed one 16-bit slice per clock,
// least significant slice first, through a single 16-bit lookahead adder.
// The carry between slices is held in a register.

// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// group-level lookahead carry network.
module CLA_16_bit_lookahead (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  // Bit-level generate/propagate and 4-bit group generate/propagate
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  // Group carries computed directly from cin, without chaining through gc
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  // Per-bit carries inside each group, expanded from the group carry-in
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

module multiword_add_sequencer #(
  parameter int WORDS = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                zero,
  output logic [CNT_W-1:0]    op_count
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry;
  logic [IW-1:0] idx;
  logic [15:0]   a_sl;
  logic [15:0]   b_sl;
  logic [15:0]   sum_sl;
  logic          add_cout;
  logic [W-1:0]  res_next;
  logic          accept;
  logic          consume;

  // A new request may enter when idle, or in DONE when the result is being
  // consumed in the same cycle; held off entirely while reset is asserted.
  assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  CLA_16_bit_lookahead u_cla (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry),
    .cout(add_cout),
    .sum (sum_sl)
  );

  // Select the current slice and form the result with that slice replaced
  always_comb begin
    a_sl     = a_q[16*idx +: 16];
    b_sl     = b_q[16*idx +: 16];
    res_next = result;
    res_next[16*idx +: 16] = sum_sl;
  end

  // Latch operands on accept; B is stored already inverted for subtraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  // Sequencer FSM with registered result, flags and consume counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry     <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            carry <= sub ? ~cin : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= res_next;
          carry  <= add_cout;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= add_cout;
            ovf       <= (a_q[W-1] == b_q[W-1]) & (sum_sl[15] != a_q[W-1]);
            zero      <= (res_next == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (consume) begin
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            if (accept) begin
              carry <= sub ? ~cin : cin;
              idx   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Testbench for multiword_add_sequencer (WORDS=4).
// Scoreboard of expected results fed by the stimulus driver and drained by
// an independent output monitor; expected values come from wide arithmetic.
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int CNT_W = 16;
  localparam int W     = 16 * WORDS;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    longint       acc;
  } exp_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a         = '0;
  logic [W-1:0]     b         = '0;
  logic             cin       = 1'b0;
  logic             sub       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [CNT_W-1:0] op_count;

  exp_t   sb[$];
  int     assertCount = 0;
  int     failCount   = 0;
  longint cycle       = 0;
  longint consumed    = 0;
  int     readyMode   = 0;
  logic   prevValid   = 1'b0;

  multiword_add_sequencer #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled
  always @(negedge clk) begin
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Reference: exact wide unsigned and signed arithmetic
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub,
                                 input longint macc);
    exp_t e;
    logic [W:0]          wide;
    logic signed [W+1:0] s;
    logic signed [W+1:0] sa;
    logic signed [W+1:0] sbv;
    sa  = $signed({{2{ma[W-1]}}, ma});
    sbv = $signed({{2{mb[W-1]}}, mb});
    if (!msub) begin
      wide   = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
      e.cout = wide[W];
      s      = sa + sbv + (W+2)'(mcin);
    end else begin
      wide   = {1'b0, ma} - {1'b0, mb} - (W+1)'(mcin);
      e.cout = ({1'b0, ma} >= ({1'b0, mb} + (W+1)'(mcin)));
      s      = sa - sbv - (W+2)'(mcin);
    end
    e.res  = wide[W-1:0];
    e.ovf  = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
    e.zero = (e.res == '0);
    e.acc  = macc;
    return e;
  endfunction

  // Present a request and hold it until accepted; record the expected result
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub,
                               input logic hold);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tcin;
    sub = tsub;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (in_ready === 1'b1) begin
        sb.push_back(model(ta, tb, tcin, tsub, cycle + 1));
        ok = 1'b1;
      end
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (!ok) reportFail("accept timeout");
    if (!hold) begin
      #1;
      in_valid = 1'b0;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head
  always begin
    @(negedge clk);
    #2;
    if (rst_n !== 1'b1) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          reportFail("unexpected result");
        end else begin
          if (!prevValid)
            checkOutput("latency", W'(cycle - sb[0].acc), W'(WORDS));
          if (out_ready !== 1'b1)
            checkOutput("stall in_ready", W'(in_ready), W'(0));
          checkOutput("result", result, sb[0].res);
          checkOutput("cout", W'(cout), W'(sb[0].cout));
          checkOutput("ovf", W'(ovf), W'(sb[0].ovf));
          checkOutput("zero", W'(zero), W'(sb[0].zero));
          if (out_ready === 1'b1) begin
            checkOutput("op_count", W'(op_count), W'(consumed[CNT_W-1:0]));
            consumed++;
            void'(sb.pop_front());
          end
        end
      end
      prevValid = (out_valid === 1'b1);
    end
  end

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && out_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) reportFail("drain timeout");
  endtask

  initial begin
    // Reset state
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", W'(out_valid), W'(0));
    checkOutput("reset result", result, '0);
    checkOutput("reset cout", W'(cout), W'(0));
    checkOutput("reset ovf", W'(ovf), W'(0));
    checkOutput("reset zero", W'(zero), W'(0));
    checkOutput("reset op_count", W'(op_count), W'(0));
    checkOutput("reset in_ready", W'(in_ready), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after reset", W'(in_ready), W'(1));

    // Directed corner cases
    readyMode = 0;
    applyStimulus({W{1'b1}}, W'(1), 1'b0, 1'b0, 1'b0);
    applyStimulus('0, W'(1), 1'b0, 1'b1, 1'b0);
    applyStimulus({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, 1'b0);
    applyStimulus({1'b1, {(W-1){1'b0}}}, W'(1), 1'b0, 1'b1, 1'b0);
    drain();

    // Back-to-back requests with in_valid held high
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b1);
    applyStimulus(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    drain();
    checkOutput("op_count after burst", W'(op_count), W'(consumed[CNT_W-1:0]));

    // Consumer stall while a new request waits
    readyMode = 2;
    applyStimulus(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0, 1'b0);
    fork
      applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1, 1'b0);
      begin
        repeat (WORDS + 10) @(negedge clk);
        readyMode = 0;
      end
    join
    drain();

    // Reset in the middle of RUN
    applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    consumed = 0;
    #1;
    checkOutput("midrun reset out_valid", W'(out_valid), W'(0));
    checkOutput("midrun reset result", result, '0);
    checkOutput("midrun reset op_count", W'(op_count), W'(0));
    checkOutput("midrun reset in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after midrun reset", W'(in_ready), W'(1));
    applyStimulus(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0);
    drain();

    // Randomized operations with a randomly stalling consumer
    readyMode = 1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    readyMode = 0;
    drain();
    @(negedge clk);
    #3;
    checkOutput("final op_count", W'(op_count), W'(consumed[CNT_W-1:0]));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
